mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single byte-serial RAM transfer engine between instruction fetch (IF) and the data cache / load-store path (DC).
- Sits between the IF/DC requesters and the transfer engine.
- Decides grant order, prevents IF starvation, and holds back IO-region stores while the IO buffer is full.
- Drops IF results killed by a pipeline flush.
- Issues one transfer at a time to the engine over a start/done handshake and routes the result back to the owner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/instruction width.
- STARVE_LIMIT, 8, consecutive cycles a pending IF may lose arbitration before it is forced ahead of DC.
- AGE_W, 4, width of the IF age counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- iIO_buffer_full  in  1  IO output buffer full
- iFlush  in  1  pipeline flush (mispredict)
- iINF_req  in  1  IF request level, held until oINF_done or flush
- iINF_addr  in  ADDR_W  fetch address
- oINF_done  out  1  one-cycle pulse, instruction valid
- oINF_inst  out  DATA_W  fetched instruction
- iDC_req  in  1  DC request level, held until oDC_done
- iDC_ls  in  1  0 load, 1 store
- iDC_len  in  3  bytes 1/2/4
- iDC_addr  in  ADDR_W  data address
- iDC_dt  in  DATA_W  store data
- oDC_done  out  1  one-cycle pulse, access complete
- oDC_dt  out  DATA_W  load data, zero-extended
- oENG_start  out  1  one-cycle pulse, launch transfer
- oENG_ls  out  1  transfer direction
- oENG_len  out  3  transfer length (4 for IF)
- oENG_addr  out  ADDR_W  transfer start address
- oENG_dt  out  DATA_W  store data
- iENG_done  in  1  engine completion pulse
- iENG_dt  in  DATA_W  engine read data
- oBusy  out  1  transfer in flight

Behaviour:
- Reset (sync, rst=1):
  - state IDLE, age=0.
  - All outputs 0.
  - Engine is reset on the same rst, so a mid-transfer reset needs no drain.
- rdy=0: state, age and all registered outputs hold. No start is issued; an oENG_start pulse already asserted is held.
- States: IDLE, RUN_IF, RUN_DC, DROP.
- DC eligible: iDC_req=1, and NOT (iDC_ls=1 AND iDC_addr[17:16]=2'b11 AND iIO_buffer_full=1).
- IF eligible: iINF_req=1 AND iFlush=0.
- IDLE grant:
  - DC is granted if eligible, unless IF is eligible and age>=STARVE_LIMIT; then IF is granted.
  - Otherwise IF is granted if eligible.
  - On grant: oENG_start=1 for one cycle; engine fields registered from the winner; next state RUN_IF or RUN_DC.
  - An IF grant always uses ls=0, len=4.
  - An IF grant is registered from the request of the grant cycle; a DC request raised one cycle later waits.
- Age counter:
  - +1 (saturating) in each IDLE cycle where IF is eligible and DC wins.
  - Cleared on IF grant, on iFlush, and when iINF_req=0.
- RUN_DC: on iENG_done, oDC_done=1 for one cycle, oDC_dt<=iENG_dt, next IDLE. iFlush is ignored; DC transfers are never cancelled.
- RUN_IF:
  - iENG_done with iFlush=0: oINF_done=1, oINF_inst<=iENG_dt, next IDLE.
  - iFlush=1 without done: next DROP.
  - iFlush=1 in the same cycle as done: result discarded, oINF_done stays 0, next IDLE.
- DROP: wait for iENG_done, discard data, next IDLE. No done pulse is issued.
- Back-to-back: completion cycle goes to IDLE; the next start is no earlier than one cycle after a done pulse. Minimum gap between transfers is 1 IDLE cycle.
- oBusy=1 in RUN_IF, RUN_DC and DROP.
- A request dropped by the requester while its transfer runs is not an error; the result is still delivered.
- Outputs registered; oINF_done and oDC_done are never both 1 in the same cycle.

Decomposition:
- Shared package/config: state encodings, Load/Store codes, IO region tag 2'b11 at addr[17:16], length codes.
- Sub-module: mem_arb_age, a saturating starvation counter with inc/clr and an at_limit flag.

Test Plan:
- IF only, addr 0x100; engine done after 5 cycles with 0x00A00093 -> start 1 cycle after req, ls=0, len=4, oINF_done pulse with oINF_inst=0x00A00093.
- IF and DC load (addr 0x2000, len 4) raised together -> DC granted first; IF granted in the IDLE cycle after oDC_done; age=1 at IF grant.
- DC requests re-raised continuously with IF pending, STARVE_LIMIT=3 -> the 4th arbitration grants IF.
- DC store to 0x30000 with iIO_buffer_full=1 and IF pending -> IF is granted and the store waits; buffer_full drops -> store start with oENG_addr=0x30000.
- Flush 2 cycles into an IF transfer -> DROP; engine done is absorbed, no oINF_done; next IF (0x200) starts the cycle after IDLE.
- rst asserted mid RUN_DC -> all outputs 0 next cycle; new request served normally; rdy=0 for 3 cycles mid-transfer -> no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - LS_*        : transfer direction codes
//   - LEN_*       : transfer length codes (bytes)
//   - IO region   : addr[17:16] == 2'b11 marks the IO-mapped region
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRunIf = 2'd1,
      StRunDc = 2'd2,
      StDrop  = 2'd3
   } arb_state_e;

   localparam logic LS_LOAD  = 1'b0;
   localparam logic LS_STORE = 1'b1;

   localparam logic [2:0] LEN_BYTE = 3'd1;
   localparam logic [2:0] LEN_HALF = 3'd2;
   localparam logic [2:0] LEN_WORD = 3'd4;

   localparam int unsigned IO_TAG_LSB    = 16;
   localparam logic [1:0]  IO_REGION_TAG = 2'b11;

   function automatic logic is_io_tag(input logic [1:0] tag);
      return tag == IO_REGION_TAG;
   endfunction

endpackage

// File: rtl/mem_arb_age.sv
// Saturating starvation counter for the pending instruction fetch.
//   clk, rst  : clock, synchronous active-high reset
//   en        : global enable; low freezes the count
//   inc       : IF was eligible but lost arbitration this cycle
//   clr       : IF granted, flushed or no longer requesting (wins over inc)
//   at_limit  : count has reached LIMIT; IF must be granted next
module mem_arb_age #(
   parameter int unsigned LIMIT = 8,
   parameter int unsigned AGE_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam logic [AGE_W-1:0] LIMIT_V = AGE_W'(LIMIT);

   logic [AGE_W-1:0] age_q, age_d;

   // Saturate at LIMIT: any value at or above it has the same effect.
   always_comb begin
      age_d = age_q;
      if (clr) begin
         age_d = '0;
      end else if (inc && (age_q < LIMIT_V)) begin
         age_d = age_q + AGE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
      end else if (en) begin
         age_q <= age_d;
      end
   end

   assign at_limit = (age_q >= LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch (IF) and the data cache / load-store path (DC)
// for the single byte-serial RAM transfer engine.
//   clk, rst, rdy         : clock, sync active-high reset, global enable
//   iIO_buffer_full       : holds back IO-region stores while set
//   iFlush                : pipeline flush; kills pending/in-flight IF results
//   iINF_* / oINF_*       : fetch request and instruction return
//   iDC_* / oDC_*         : load/store request and load data return
//   oENG_* / iENG_*       : start/done handshake with the transfer engine
//   oBusy                 : a transfer is in flight
// All outputs are registered; one transfer is outstanding at a time.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned AGE_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iIO_buffer_full,
   input  logic              iFlush,
   input  logic              iINF_req,
   input  logic [ADDR_W-1:0] iINF_addr,
   output logic              oINF_done,
   output logic [DATA_W-1:0] oINF_inst,
   input  logic              iDC_req,
   input  logic              iDC_ls,
   input  logic [2:0]        iDC_len,
   input  logic [ADDR_W-1:0] iDC_addr,
   input  logic [DATA_W-1:0] iDC_dt,
   output logic              oDC_done,
   output logic [DATA_W-1:0] oDC_dt,
   output logic              oENG_start,
   output logic              oENG_ls,
   output logic [2:0]        oENG_len,
   output logic [ADDR_W-1:0] oENG_addr,
   output logic [DATA_W-1:0] oENG_dt,
   input  logic              iENG_done,
   input  logic [DATA_W-1:0] iENG_dt,
   output logic              oBusy
);

   arb_state_e        state_q, state_d;
   logic              start_q, start_d;
   logic              ls_q, ls_d;
   logic [2:0]        len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dt_q, dt_d;
   logic              inf_done_q, inf_done_d;
   logic [DATA_W-1:0] inf_inst_q, inf_inst_d;
   logic              dc_done_q, dc_done_d;
   logic [DATA_W-1:0] dc_dt_q, dc_dt_d;

   logic              dc_io_blocked, dc_elig, if_elig;
   logic              age_inc, age_clr, age_at_limit;
   logic [DATA_W-1:0] load_mask;

   assign dc_io_blocked = (iDC_ls == LS_STORE) &&
                          is_io_tag(iDC_addr[IO_TAG_LSB+1:IO_TAG_LSB]) && iIO_buffer_full;
   assign dc_elig       = iDC_req && !dc_io_blocked;
   assign if_elig       = iINF_req && !iFlush;

   // len_q still holds the length of the DC transfer in flight.
   always_comb begin
      load_mask = '1;
      if (len_q == LEN_BYTE) begin
         load_mask = DATA_W'(8'hFF);
      end else if (len_q == LEN_HALF) begin
         load_mask = DATA_W'(16'hFFFF);
      end
   end

   mem_arb_age #(
      .LIMIT (STARVE_LIMIT),
      .AGE_W (AGE_W)
   ) u_age (
      .clk      (clk),
      .rst      (rst),
      .en       (rdy),
      .inc      (age_inc),
      .clr      (age_clr),
      .at_limit (age_at_limit)
   );

   always_comb begin
      state_d    = state_q;
      start_d    = 1'b0;
      ls_d       = ls_q;
      len_d      = len_q;
      addr_d     = addr_q;
      dt_d       = dt_q;
      inf_done_d = 1'b0;
      inf_inst_d = inf_inst_q;
      dc_done_d  = 1'b0;
      dc_dt_d    = dc_dt_q;
      age_inc    = 1'b0;
      age_clr    = iFlush || !iINF_req;

      unique case (state_q)
         StIdle: begin
            if (dc_elig && !(if_elig && age_at_limit)) begin
               state_d = StRunDc;
               start_d = 1'b1;
               ls_d    = iDC_ls;
               len_d   = iDC_len;
               addr_d  = iDC_addr;
               dt_d    = iDC_dt;
               age_inc = if_elig;
            end else if (if_elig) begin
               state_d = StRunIf;
               start_d = 1'b1;
               ls_d    = LS_LOAD;
               len_d   = LEN_WORD;
               addr_d  = iINF_addr;
               dt_d    = '0;
               age_clr = 1'b1;
            end
         end

         StRunIf: begin
            if (iENG_done) begin
               // A flush coinciding with done discards the result.
               state_d = StIdle;
               if (!iFlush) begin
                  inf_done_d = 1'b1;
                  inf_inst_d = iENG_dt;
               end
            end else if (iFlush) begin
               state_d = StDrop;
            end
         end

         StRunDc: begin
            if (iENG_done) begin
               state_d   = StIdle;
               dc_done_d = 1'b1;
               dc_dt_d   = iENG_dt & load_mask;
            end
         end

         StDrop: begin
            if (iENG_done) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         ls_q       <= 1'b0;
         len_q      <= '0;
         addr_q     <= '0;
         dt_q       <= '0;
         inf_done_q <= 1'b0;
         inf_inst_q <= '0;
         dc_done_q  <= 1'b0;
         dc_dt_q    <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         start_q    <= start_d;
         ls_q       <= ls_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         dt_q       <= dt_d;
         inf_done_q <= inf_done_d;
         inf_inst_q <= inf_inst_d;
         dc_done_q  <= dc_done_d;
         dc_dt_q    <= dc_dt_d;
      end
   end

   assign oENG_start = start_q;
   assign oENG_ls    = ls_q;
   assign oENG_len   = len_q;
   assign oENG_addr  = addr_q;
   assign oENG_dt    = dt_q;
   assign oINF_done  = inf_done_q;
   assign oINF_inst  = inf_inst_q;
   assign oDC_done   = dc_done_q;
   assign oDC_dt     = dc_dt_q;
   assign oBusy      = (state_q != StIdle);

endmodule
